bias_add_sequencer: RTL
=======================

# bias_add_sequencer

Sequences the FP16 bias-add vector adder over vectors longer than its lane count. The sequencer accepts a job of `job_len` elements and steps through it in chunks of `NUM_UNITS` lanes. For each chunk it drives the adder's start/ready handshake and generates the lane mask, with a partial mask for the tail chunk. Each result chunk is presented downstream on a single-entry valid/ready output register. It sits between the layer controller (job interface) and the activation buffer write port (result interface).

## Interface

- `DATA_WIDTH`, 16, element width (FP16 bit pattern, passed through untouched).
- `NUM_UNITS`, 16, adder lane count = chunk size.
- `LEN_WIDTH`, 10, width of `job_len`; max job length 2^LEN_WIDTH-1.
- `CHUNK_WIDTH`, LEN_WIDTH, width of the chunk index.

Ports (one clock; reset is synchronous and active-high; all outputs registered):

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high; returns the block to IDLE.
- `job_start`  in  1  one-cycle job request; sampled in IDLE only.
- `job_len`  in  LEN_WIDTH  element count, sampled with `job_start`.
- `busy`  out  1  high from job acceptance until the `job_done` cycle, inclusive.
- `job_done`  out  1  one-cycle pulse when the job is complete.
- `chunk_idx`  out  CHUNK_WIDTH  current chunk; operand buffers index x/bias with it.
- `va_start`  out  1  to vector adder `start`.
- `va_active_units`  out  NUM_UNITS  to vector adder `active_units`.
- `va_ready`  in  1  from vector adder `ready`.
- `va_out`  in  DATA_WIDTH x NUM_UNITS  from vector adder `Out`.
- `out_valid`  out  1  result chunk available.
- `out_ready`  in  1  downstream accepts when `out_valid && out_ready`.
- `out_data`  out  DATA_WIDTH x NUM_UNITS  captured chunk; inactive lanes forced to 0.
- `out_mask`  out  NUM_UNITS  lane mask of the captured chunk.
- `out_chunk`  out  CHUNK_WIDTH  chunk index of `out_data`.
- `out_last`  out  1  the captured chunk is the final chunk of the job.

## Operation

- Reset values: all outputs 0, state IDLE, chunk counter 0.
- Chunk count: `n_chunks = ceil(len/NUM_UNITS)`. The last chunk has `rem = len % NUM_UNITS`.
- Lane mask: all ones, except the last chunk when `rem != 0`, where the mask is the low `rem` bits set.

State machine:

- **IDLE**
  - `job_start && job_len != 0`: latch the length, set `chunk_idx = 0`, `busy = 1`, go to ISSUE.
  - `job_start && job_len == 0`: pulse `job_done` next cycle, stay in IDLE, no `va_start`.
- **ISSUE**
  - Hold `va_start = 1`.
  - Hold `va_active_units` and `chunk_idx` stable.
  - On `va_ready == 1`: load `out_data` (masked), `out_mask`, `out_chunk`, `out_last`; set `out_valid = 1`; go to RELEASE.
- **RELEASE**
  - Hold `va_start = 0` so the adder's DONE state returns to IDLE.
  - Leave when `va_ready == 0` and the output register is free, i.e. `!out_valid`, or `out_valid && out_ready` in the same cycle.
  - If more chunks remain: increment `chunk_idx`, go to ISSUE.
  - Otherwise: go to FINISH.
- **FINISH**
  - `job_done = 1` for one cycle, `busy = 0`, go to IDLE.
- Output register: `out_valid` clears on `out_valid && out_ready`. The register never holds two chunks.
- `job_start` while `busy` is ignored, with no side effects.
- `va_out` is sampled only in the ISSUE cycle where `va_ready` is high. It is never sampled in RELEASE, where ready is still high from the previous handshake.
- Reset mid-job:
  - Next cycle the block is in IDLE with all outputs 0; the pending chunk is discarded.
  - The adder shares the same `reset` net, so the pair restarts clean.

## Timing

- Job accepted in cycle T: `va_start` high at T+1.
- Adder handshake, with `va_ready` first seen at cycle R:
  - `out_valid` rises at R+1.
  - `va_start` falls at R+1.
- RELEASE exit is the first cycle with `va_ready == 0` and the output register free. The next `va_start` rises one cycle after that.
- Minimum per-chunk overhead beyond adder latency: 2 cycles (capture plus release).
- `job_done` rises exactly one cycle after the final RELEASE exit. At that point the last chunk has already been accepted downstream.
- `va_start` is never high while `va_ready` is high from a previous chunk.

## Test plan

- **Tail chunk, len=40, adder model x+bias, `out_ready` tied 1:**
  - Chunks 0, 1, 2 with `out_mask` 16'hFFFF, 16'hFFFF, 16'h00FF.
  - Chunk 2 lanes 8-15 of `out_data` are 0.
  - `out_last` high only on chunk 2.
  - `job_done` pulses once.
- **Exact multiple, len=32, x=16'h3C00, bias=16'h3800:**
  - Every active lane is 16'h3E00.
  - Two chunks, both mask 16'hFFFF; the second has `out_last` = 1.
- **Zero length, `job_start` with `job_len=0`:**
  - `job_done` at the next cycle.
  - `va_start` and `out_valid` stay 0.
  - `busy` stays 0.
- **Backpressure, len=48, `out_ready` low for 20 cycles after the first `out_valid`:**
  - State holds in RELEASE and `va_start` stays 0.
  - Chunk 0 data stays stable.
  - Chunk 1 issues one cycle after `out_ready` rises.
- **Reset mid-ISSUE on chunk 1 of len=40:**
  - Next cycle all outputs are 0 and the block is in IDLE.
  - A new job len=16 then completes normally with mask 16'hFFFF.
- **`job_start` pulsed during RELEASE of a len=40 job:**
  - Ignored; exactly 3 chunks are produced.
  - `job_done` pulses once.

Source files
------------

// File: rtl/bias_add_sequencer.sv
// Steps an FP16 bias-add job through the vector adder one NUM_UNITS-lane chunk at a time,
// masking the tail chunk and holding each result in a single-entry valid/ready register.
module bias_add_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_UNITS   = 16,
  parameter int LEN_WIDTH   = 10,
  parameter int CHUNK_WIDTH = LEN_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            job_start,
  input  logic [LEN_WIDTH-1:0]            job_len,
  output logic                            busy,
  output logic                            job_done,
  output logic [CHUNK_WIDTH-1:0]          chunk_idx,
  output logic                            va_start,
  output logic [NUM_UNITS-1:0]            va_active_units,
  input  logic                            va_ready,
  input  logic [DATA_WIDTH*NUM_UNITS-1:0] va_out,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH*NUM_UNITS-1:0] out_data,
  output logic [NUM_UNITS-1:0]            out_mask,
  output logic [CHUNK_WIDTH-1:0]          out_chunk,
  output logic                            out_last
);

  localparam int REM_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RELEASE,
    S_FINISH
  } state_t;

  state_t                          r_state, w_state_next;
  logic                            r_busy, w_busy;
  logic                            r_job_done, w_job_done;
  logic [CHUNK_WIDTH-1:0]          r_chunk_idx, w_chunk_idx;
  logic                            r_va_start, w_va_start;
  logic [NUM_UNITS-1:0]            r_va_active_units, w_va_active_units;
  logic                            r_out_valid, w_out_valid;
  logic [DATA_WIDTH*NUM_UNITS-1:0] r_out_data, w_out_data;
  logic [NUM_UNITS-1:0]            r_out_mask, w_out_mask;
  logic [CHUNK_WIDTH-1:0]          r_out_chunk, w_out_chunk;
  logic                            r_out_last, w_out_last;
  logic [CHUNK_WIDTH-1:0]          r_last_idx, w_last_idx;
  logic [REM_W-1:0]                r_rem, w_rem;

  logic [LEN_WIDTH-1:0]            w_len_m1;
  logic [CHUNK_WIDTH-1:0]          w_job_last_idx;
  logic [REM_W-1:0]                w_job_rem;
  logic [DATA_WIDTH*NUM_UNITS-1:0] w_masked;
  logic                            w_out_free;

  // Full mask everywhere except a tail chunk whose length is not a lane multiple.
  function automatic logic [NUM_UNITS-1:0] f_lane_mask(
    input logic [CHUNK_WIDTH-1:0] idx,
    input logic [CHUNK_WIDTH-1:0] last_idx,
    input logic [REM_W-1:0]       rem
  );
    logic [NUM_UNITS-1:0] m;
    m = '1;
    if (idx == last_idx && rem != '0)
      for (int l = 0; l < NUM_UNITS; l++) m[l] = (l < int'(rem));
    return m;
  endfunction

  assign w_len_m1       = job_len - 1'b1;
  assign w_job_last_idx = CHUNK_WIDTH'(w_len_m1 / LEN_WIDTH'(NUM_UNITS));
  assign w_job_rem      = REM_W'(job_len % LEN_WIDTH'(NUM_UNITS));
  assign w_out_free     = !r_out_valid || out_ready;

  always_comb begin
    w_masked = '0;
    for (int l = 0; l < NUM_UNITS; l++)
      if (r_va_active_units[l])
        w_masked[l*DATA_WIDTH +: DATA_WIDTH] = va_out[l*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    w_state_next      = r_state;
    w_busy            = r_busy;
    w_job_done        = 1'b0;
    w_chunk_idx       = r_chunk_idx;
    w_va_start        = r_va_start;
    w_va_active_units = r_va_active_units;
    w_out_valid       = r_out_valid && !out_ready;
    w_out_data        = r_out_data;
    w_out_mask        = r_out_mask;
    w_out_chunk       = r_out_chunk;
    w_out_last        = r_out_last;
    w_last_idx        = r_last_idx;
    w_rem             = r_rem;

    case (r_state)
      S_IDLE: begin
        if (job_start) begin
          if (job_len != '0) begin
            w_state_next      = S_ISSUE;
            w_busy            = 1'b1;
            w_chunk_idx       = '0;
            w_va_start        = 1'b1;
            w_last_idx        = w_job_last_idx;
            w_rem             = w_job_rem;
            w_va_active_units = f_lane_mask('0, w_job_last_idx, w_job_rem);
          end else begin
            w_job_done = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        // The output register is always free here, so the capture never overwrites a chunk.
        if (va_ready) begin
          w_state_next = S_RELEASE;
          w_va_start   = 1'b0;
          w_out_valid  = 1'b1;
          w_out_data   = w_masked;
          w_out_mask   = r_va_active_units;
          w_out_chunk  = r_chunk_idx;
          w_out_last   = (r_chunk_idx == r_last_idx);
        end
      end
      S_RELEASE: begin
        if (!va_ready && w_out_free) begin
          if (r_chunk_idx != r_last_idx) begin
            w_state_next      = S_ISSUE;
            w_chunk_idx       = r_chunk_idx + 1'b1;
            w_va_start        = 1'b1;
            w_va_active_units = f_lane_mask(w_chunk_idx, r_last_idx, r_rem);
          end else begin
            w_state_next = S_FINISH;
            w_job_done   = 1'b1;
          end
        end
      end
      S_FINISH: begin
        w_state_next = S_IDLE;
        w_busy       = 1'b0;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_busy            <= 1'b0;
      r_job_done        <= 1'b0;
      r_chunk_idx       <= '0;
      r_va_start        <= 1'b0;
      r_va_active_units <= '0;
      r_out_valid       <= 1'b0;
      r_out_data        <= '0;
      r_out_mask        <= '0;
      r_out_chunk       <= '0;
      r_out_last        <= 1'b0;
      r_last_idx        <= '0;
      r_rem             <= '0;
    end else begin
      r_state           <= w_state_next;
      r_busy            <= w_busy;
      r_job_done        <= w_job_done;
      r_chunk_idx       <= w_chunk_idx;
      r_va_start        <= w_va_start;
      r_va_active_units <= w_va_active_units;
      r_out_valid       <= w_out_valid;
      r_out_data        <= w_out_data;
      r_out_mask        <= w_out_mask;
      r_out_chunk       <= w_out_chunk;
      r_out_last        <= w_out_last;
      r_last_idx        <= w_last_idx;
      r_rem             <= w_rem;
    end
  end

  assign busy            = r_busy;
  assign job_done        = r_job_done;
  assign chunk_idx       = r_chunk_idx;
  assign va_start        = r_va_start;
  assign va_active_units = r_va_active_units;
  assign out_valid       = r_out_valid;
  assign out_data        = r_out_data;
  assign out_mask        = r_out_mask;
  assign out_chunk       = r_out_chunk;
  assign out_last        = r_out_last;

endmodule
